seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Scan controller for the 4-digit multiplexed 7-segment display.
- Generates its own refresh tick as a single-cycle clock enable rather than a derived clock. Sequences the anodes with an anti-ghost blanking window.
- Owns a shadow digit register. The ROM data-processing path may update it only at frame boundaries, through a req/ack handshake, so a frame is never torn.

Parameters:
- BASE_SHIFT, 13: log2 of the shortest digit-slot period in clk cycles. Benches use 2.
- BLANK_CYC, 4: cycles at the start of each digit slot during which all anodes are off. Must be less than 2^BASE_SHIFT.

Ports:
- clk  in  1  system clock
- clr  in  1  reset
- div_sel  in  2  slot period select: 2^(BASE_SHIFT+div_sel) cycles
- load_req  in  1  requester asks to replace the displayed value
- load_data  in  16  four hex nibbles; [15:12] is the leftmost digit (an[3]), [3:0] is the rightmost (an[0])
- load_ack  out  1  one-cycle pulse: load_data has been captured
- blank_en  in  1  1 = all anodes off (display dark), scanning continues
- an  out  4  anode enables, active-low, one-hot-low when lit
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- frame_done  out  1  one-cycle pulse when the digit index wraps 3->0

Interface: reset clr, asynchronous, active-high; clock clk. All outputs are registered.

Behaviour:
- Reset values:
  - Cycle counter = 0, digit index = 0, shadow = 16'h0000, active period = 2^BASE_SHIFT.
  - an = 4'b1111, seg = 7'b1111111, load_ack = 0, frame_done = 0, FSM = BLANK.
- Reset mid-operation clears everything immediately, including a pending handshake. No ack is issued for a request outstanding at reset.
- Tick generation:
  - A counter of width BASE_SHIFT+3 increments every cycle.
  - tick asserts when counter == active_period-1; the counter then wraps to 0.
  - div_sel is sampled only on tick and takes effect for the next slot. A mid-slot change never shortens or lengthens the current slot.
- FSM states: BLANK, LIT.
  - BLANK: an = 1111. After BLANK_CYC cycles from slot start (counter == BLANK_CYC-1), go to LIT.
  - LIT: an[digit] = 0, others 1; seg = decode(shadow nibble[digit]).
  - On tick from either state: digit <= digit+1 (mod 4), go to BLANK.
  - seg and an change together on the same edge, one cycle after the state decision.
- blank_en = 1 forces an = 1111 in LIT. The FSM, ticks, frame_done and loads are unaffected.
- Frame boundary is a tick with digit == 3.
  - frame_done pulses on the cycle after that tick.
  - If load_req = 1 at that tick: shadow <= load_data and load_ack pulses on the same cycle as frame_done. The new value is shown starting at digit 0 of the new frame.
- Handshake rules:
  - The requester holds load_req and load_data stable until it sees load_ack.
  - load_req still high after ack is a new request, served at the next frame boundary.
  - load_req dropped before a boundary means no load.
- Decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Width: counter compares use the full BASE_SHIFT+3 bits. div_sel=3 gives 2^(BASE_SHIFT+3), which needs no extra bit.

Test Plan:
- Reset, then idle (BASE_SHIFT=2, div_sel=0, BLANK_CYC=1):
  - Ticks occur every 4 cycles and digit slots cycle an 0,1,2,3.
  - an = 1111 for cycle 1 of each slot, then the active-low one-hot pattern for 3 cycles.
  - seg = 1000000 throughout LIT, since the shadow is 0000.
  - frame_done pulses every 16 cycles.
- Load mid-frame: load_req=1, load_data=16'h1A3F during digit 1:
  - No change until the digit 3->0 boundary.
  - load_ack and frame_done pulse on the same cycle.
  - Next frame shows an[3]=1111001, an[2]=0001000, an[1]=0110000, an[0]=0001110.
- Held request: load_req stays high across two boundaries with data 16'h0001 then 16'h0002:
  - Two acks, exactly one frame apart.
  - The second frame shows 0002 and no partial frame is ever shown.
- div_sel changed 0->3 mid-slot: the current slot completes at 4 cycles and the next slot lasts 32 cycles.
- blank_en=1 for one full frame: an = 1111 throughout, while frame_done still pulses every 16 cycles.
- clr asserted for 1 cycle while load_req=1 and digit=2:
  - Outputs return to reset values asynchronously and no load_ack is issued.
  - Scanning restarts at digit 0 with shadow 0000.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - frame-boundary load handshake between the ROM data path and the scan controller
interface seg_scan_ctrl_if;
  logic        load_req;
  logic [15:0] load_data;
  logic        load_ack;

  modport master (output load_req, output load_data, input load_ack);
  modport slave  (input load_req, input load_data, output load_ack);
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit multiplexed 7-segment scan controller with blanking and tear-free shadow load
module seg_scan_ctrl #(
  parameter int BASE_SHIFT = 13,
  parameter int BLANK_CYC  = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       div_sel,
  input  logic             blank_en,
  seg_scan_ctrl_if.slave   ld,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic             frame_done
);

  localparam int CW = BASE_SHIFT + 3;

  typedef enum logic {BLANK, LIT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] last;
  logic [1:0]    sel;
  logic [1:0]    digit;
  logic [15:0]   shadow;
  logic [3:0]    nib;
  logic          tick, blank_done, frame;
  logic [3:0]    an_nx;
  logic [6:0]    seg_nx;

  // Slot length is 2^(BASE_SHIFT+sel); for sel=3 the mask covers every counter bit.
  assign last       = ~({CW{1'b1}} << (BASE_SHIFT + 32'(sel)));
  assign tick       = (cnt == last);
  assign blank_done = (cnt == CW'(BLANK_CYC - 1));
  assign frame      = tick && (digit == 2'd3);
  assign nib        = shadow[{digit, 2'b00} +: 4];

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  // Outputs are registered from the next state so an and seg switch on the same edge as the FSM.
  always_comb begin
    state_nx = state;
    an_nx    = 4'b1111;
    seg_nx   = 7'b1111111;
    if (tick)
      state_nx = BLANK;
    else if (state == BLANK && blank_done)
      state_nx = LIT;
    if (state_nx == LIT) begin
      seg_nx = decode(nib);
      if (!blank_en)
        an_nx = 4'(~(4'b0001 << digit));
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= BLANK;
      cnt         <= '0;
      sel         <= 2'd0;
      digit       <= 2'd0;
      shadow      <= 16'h0000;
      an          <= 4'b1111;
      seg         <= 7'b1111111;
      frame_done  <= 1'b0;
      ld.load_ack <= 1'b0;
    end else begin
      state       <= state_nx;
      an          <= an_nx;
      seg         <= seg_nx;
      frame_done  <= frame;
      ld.load_ack <= frame && ld.load_req;
      if (frame && ld.load_req)
        shadow <= ld.load_data;
      if (tick) begin
        cnt   <= '0;
        sel   <= div_sel;
        digit <= digit + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized scoreboard bench for seg_scan_ctrl
module tb_seg_scan_ctrl;
  localparam int BS = 2;
  localparam int BC = 1;
  localparam logic [6:0] DEC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic       clk = 1'b0;
  logic       clr;
  logic [1:0] div_sel;
  logic       blank_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_done;

  seg_scan_ctrl_if ld();

  seg_scan_ctrl #(.BASE_SHIFT(BS), .BLANK_CYC(BC)) dut (
    .clk(clk), .clr(clr), .div_sel(div_sel), .blank_en(blank_en),
    .ld(ld), .an(an), .seg(seg), .frame_done(frame_done));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       chk_seg;
    logic       fd;
    logic       ack;
  } exp_t;

  exp_t        q[$];
  logic [15:0] req_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          armed = 0;

  // Reference model: position inside the current slot, slot length, digit and displayed value.
  int          pos, slen, m_digit;
  logic [15:0] m_shadow;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    exp_t e;
    int   nibv;
    bit   lit;
    if (clr) begin
      pos = 0; slen = 1 << BS; m_digit = 0; m_shadow = 16'h0000;
      e = '{4'hF, 7'h7F, 1'b0, 1'b0, 1'b0};
    end else begin
      e.fd = 1'b0;
      e.ack = 1'b0;
      if (pos == slen - 1) begin
        if (m_digit == 3) begin
          e.fd = 1'b1;
          if (ld.load_req) begin
            e.ack = 1'b1;
            m_shadow = ld.load_data;
          end
        end
        m_digit = (m_digit + 1) % 4;
        slen = 1 << (BS + int'(div_sel));
        pos = 0;
      end else begin
        pos++;
      end
      lit = (pos >= BC);
      nibv = int'((m_shadow >> (4 * m_digit)) & 16'hF);
      e.an = (lit && !blank_en) ? 4'(~(4'b0001 << m_digit)) : 4'hF;
      e.seg = DEC[nibv];
      e.chk_seg = lit;
    end
    q.push_back(e);
    armed = 1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_empty cyc=%0d got=0 entries exp=1", cyc);
      end else begin
        e = q.pop_front();
        chk("an", {12'h0, an}, {12'h0, e.an});
        if (e.chk_seg) chk("seg", {9'h0, seg}, {9'h0, e.seg});
        chk("frame_done", {15'h0, frame_done}, {15'h0, e.fd});
        chk("load_ack", {15'h0, ld.load_ack}, {15'h0, e.ack});
      end
    end
  end

  // Requester: on ack either present the next queued value or withdraw.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      if (ld.load_ack === 1'b1) begin
        if (req_q.size() > 0) ld.load_data = req_q.pop_front();
        else ld.load_req = 1'b0;
      end
    end
  endtask

  task automatic wait_digit(input int d);
    for (int i = 0; i < 400 && m_digit != d; i++) run(1);
    chk("wait_digit", 16'(m_digit), 16'(d));
  endtask

  task automatic reset_check();
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_seg", {9'h0, seg}, 16'h007F);
    chk("rst_fd", {15'h0, frame_done}, 16'h0);
    chk("rst_ack", {15'h0, ld.load_ack}, 16'h0);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end

  initial begin
    clr = 1'b1; div_sel = 2'd0; blank_en = 1'b0;
    ld.load_req = 1'b0; ld.load_data = 16'h0000;
    run(2);
    reset_check();
    clr = 1'b0;
    run(40);

    wait_digit(1);
    ld.load_data = 16'h1A3F; ld.load_req = 1'b1;
    run(48);

    req_q.push_back(16'h0002);
    ld.load_data = 16'h0001; ld.load_req = 1'b1;
    run(80);
    ld.load_req = 1'b0;

    for (int i = 0; i < 8 && pos != 1; i++) run(1);
    div_sel = 2'd3;
    run(140);
    div_sel = 2'd0;
    run(140);

    blank_en = 1'b1;
    run(40);
    blank_en = 1'b0;
    run(8);

    wait_digit(2);
    ld.load_data = 16'hBEEF; ld.load_req = 1'b1;
    @(negedge clk);
    #1 clr = 1'b1;
    #1 reset_check();
    run(1);
    clr = 1'b0; ld.load_req = 1'b0;
    run(40);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(39) == 0) blank_en = ~blank_en;
      if ($urandom_range(99) == 0) div_sel = ($urandom_range(3) == 0) ? 2'(($urandom_range(3))) : 2'(($urandom_range(1)));
      if (!ld.load_req && $urandom_range(29) == 0) begin
        ld.load_data = 16'($urandom);
        ld.load_req = 1'b1;
        if ($urandom_range(2) == 0) req_q.push_back(16'($urandom));
      end else if (ld.load_req && !ld.load_ack && $urandom_range(199) == 0) begin
        ld.load_req = 1'b0;
        req_q.delete();
      end
      run(1);
    end
    ld.load_req = 1'b0;
    run(2);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
